hs_rx_ctrl: RTL

- Destination-side controller for a 4-phase bundled-data req/ack clock-domain crossing.
- Synchronizes the incoming async_req into the clk domain and captures async_data once req is stable.
- Presents the captured word to a local consumer via a valid/ready handshake.
- Sequences async_ack back to the source domain. Sits at the receive edge of every multi-bit CDC path; only req is synchronized, data is never synchronized.

---
 rtl/hs_rx_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/hs_rx_ctrl.sv
// Receive-side controller for a 4-phase bundled-data req/ack CDC: syncs req, captures data, hands it to a valid/ready consumer.
// Optional ACK-phase timeout detector enabled by defining HS_RX_TIMEOUT_EN.
module hs_rx_ctrl #(
  parameter int WIDTH   = 8,
  parameter int STAGE   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_req,
  input  logic [WIDTH-1:0] async_data,
  output logic             async_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      xfer_cnt,
  input  logic             err_clr,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state;
  logic [STAGE-1:0] sync;
  logic             req_s;

  // Only req crosses through a synchronizer; data is bundled and is
  // guaranteed stable by the source for as long as req is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[STAGE-2:0], async_req};
  end

  assign req_s = sync[STAGE-1];
  assign busy  = (state != IDLE);

  // NOTE: all state updates use <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      async_ack <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      xfer_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s) begin
            out_data  <= async_data;
            out_valid <= 1'b1;
            state     <= VALID;
          end
        end
        VALID: begin
          // A req drop here is a source protocol violation; we still wait for the consumer.
          if (out_ready) begin
            out_valid <= 1'b0;
            async_ack <= 1'b1;
            xfer_cnt  <= xfer_cnt + 16'd1;
            state     <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            async_ack <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HS_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;
  logic          ack_hold;

  assign ack_hold = (state == ACK) && req_s;

  // Counter saturates at TIMEOUT so the error fires once per stuck ACK phase,
  // letting err_clr take effect even while req is still held high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == VALID && out_ready)
        tmo_cnt <= '0;
      else if (ack_hold && tmo_cnt != CW'(TIMEOUT))
        tmo_cnt <= tmo_cnt + 1'b1;

      if (ack_hold && tmo_cnt == CW'(TIMEOUT - 1))
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign timeout_err    = 1'b0;
`endif

endmodule
